// File: rtl/tempsens_result_filter.sv
// rtl/tempsens_result_filter.sv - moving average, min/max and staleness tracking of raw tempsens results
module tempsens_result_filter #(
  parameter int N_VDAC       = 6,
  parameter int LOG2_AVG     = 2,
  parameter int STALE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_res_valid,
  input  logic [N_VDAC-1:0] i_res_raw,
  input  logic [1:0]        i_sel,
  input  logic              i_clr_minmax,
  output logic [N_VDAC-1:0] o_res,
  output logic              o_res_valid,
  output logic              o_primed,
  output logic              o_stale
);

  localparam int DEPTH = 1 << LOG2_AVG;
  localparam int SW    = N_VDAC + LOG2_AVG;
  localparam int CW    = $clog2(STALE_CYCLES + 1);
  localparam int HALF  = 1 << (LOG2_AVG - 1);

  logic [N_VDAC-1:0]   win [DEPTH];
  logic [SW-1:0]       sum, sum_next;
  logic [LOG2_AVG-1:0] wp;
  logic [N_VDAC-1:0]   raw_q, min_q, max_q, filt_q, filt_next;
  logic                reload, primed, valid_q, stale_q;
  logic [CW-1:0]       cnt, cnt_next;

  always_comb begin
    sum_next = sum;
    if (i_res_valid) begin
      if (!primed) sum_next = SW'(i_res_raw) << LOG2_AVG;
      else         sum_next = sum - SW'(win[wp]) + SW'(i_res_raw);
    end
    // Rounded window mean; the largest possible sum plus HALF still fits in SW bits.
    filt_next = N_VDAC'((sum_next + SW'(HALF)) >> LOG2_AVG);

    if (i_res_valid)                    cnt_next = '0;
    else if (cnt == CW'(STALE_CYCLES))  cnt_next = cnt;
    else                                cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      sum     <= '0;
      wp      <= '0;
      raw_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      filt_q  <= '0;
      reload  <= 1'b0;
      primed  <= 1'b0;
      valid_q <= 1'b0;
      stale_q <= 1'b0;
      cnt     <= '0;
    end else begin
      valid_q <= i_res_valid;
      cnt     <= cnt_next;
      stale_q <= (cnt_next == CW'(STALE_CYCLES));
      if (i_res_valid) begin
        sum    <= sum_next;
        filt_q <= filt_next;
        raw_q  <= i_res_raw;
        if (!primed) begin
          for (int i = 0; i < DEPTH; i++) win[i] <= i_res_raw;
          wp     <= LOG2_AVG'(1);
          min_q  <= i_res_raw;
          max_q  <= i_res_raw;
          primed <= 1'b1;
          reload <= 1'b0;
        end else begin
          win[wp] <= i_res_raw;
          wp      <= wp + 1'b1;
          // A pending or concurrent clear makes this sample the new extremes.
          if (reload || i_clr_minmax) begin
            min_q  <= i_res_raw;
            max_q  <= i_res_raw;
            reload <= 1'b0;
          end else begin
            if (i_res_raw < min_q) min_q <= i_res_raw;
            if (i_res_raw > max_q) max_q <= i_res_raw;
          end
        end
      end else if (i_clr_minmax && primed) begin
        reload <= 1'b1;
      end
    end
  end

  always_comb begin
    o_res = filt_q;
    case (i_sel)
      2'd0:    o_res = filt_q;
      2'd1:    o_res = raw_q;
      2'd2:    o_res = min_q;
      default: o_res = max_q;
    endcase
  end

  assign o_res_valid = valid_q;
  assign o_primed    = primed;
  assign o_stale     = stale_q;

endmodule

// File: tb/tb_tempsens_result_filter.sv
// tb/tb_tempsens_result_filter.sv - self-checking bench for tempsens_result_filter
`timescale 1ns/100ps
module tb_tempsens_result_filter;

  localparam int N     = 6;
  localparam int L     = 2;
  localparam int STALE = 1024;
  localparam int DEPTH = 1 << L;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_res_valid = 1'b0;
  logic [N-1:0] i_res_raw = '0;
  logic [1:0]   i_sel = 2'd0;
  logic         i_clr_minmax = 1'b0;
  logic [N-1:0] o_res;
  logic         o_res_valid, o_primed, o_stale;

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_win[$];
  int m_primed, m_raw, m_min, m_max, m_reload, m_cnt, m_vld;

  tempsens_result_filter #(.N_VDAC(N), .LOG2_AVG(L), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .reset(reset), .i_res_valid(i_res_valid), .i_res_raw(i_res_raw),
    .i_sel(i_sel), .i_clr_minmax(i_clr_minmax), .o_res(o_res),
    .o_res_valid(o_res_valid), .o_primed(o_primed), .o_stale(o_stale)
  );

  always #10 clk = ~clk;

  function automatic int m_filt();
    int s = 0;
    foreach (m_win[i]) s += m_win[i];
    return (s + DEPTH / 2) / DEPTH;
  endfunction

  function automatic int m_sel(input int sel);
    if (!m_primed) return 0;
    case (sel)
      0: return m_filt();
      1: return m_raw;
      2: return m_min;
      default: return m_max;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_win = {};
    for (int i = 0; i < DEPTH; i++) m_win.push_back(0);
    m_primed = 0; m_raw = 0; m_min = 0; m_max = 0;
    m_reload = 0; m_cnt = 0; m_vld = 0;
  endtask

  task automatic model_update(input int v, input int s, input int clr);
    m_vld = v;
    if (v) begin
      if (!m_primed) begin
        m_win = {};
        for (int i = 0; i < DEPTH; i++) m_win.push_back(s);
        m_min = s; m_max = s; m_primed = 1; m_reload = 0;
      end else begin
        void'(m_win.pop_front());
        m_win.push_back(s);
        if (m_reload || clr) begin
          m_min = s; m_max = s; m_reload = 0;
        end else begin
          if (s < m_min) m_min = s;
          if (s > m_max) m_max = s;
        end
      end
      m_raw = s;
      m_cnt = 0;
    end else begin
      if (clr && m_primed) m_reload = 1;
      if (m_cnt < STALE) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  int'(o_res_valid), m_vld);
    check({tag, ".primed"}, int'(o_primed),    m_primed);
    check({tag, ".stale"},  int'(o_stale),     int'(m_cnt == STALE));
    for (int s = 0; s < 4; s++) begin
      i_sel = 2'(s);
      #1;
      check($sformatf("%s.sel%0d", tag, s), int'(o_res), m_sel(s));
    end
  endtask

  task automatic cycle(input int v, input int s, input int clr);
    i_res_valid = v[0]; i_res_raw = N'(s); i_clr_minmax = clr[0];
    @(posedge clk);
    #1;
    i_res_valid = 1'b0; i_clr_minmax = 1'b0;
    model_update(v, s, clr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic sample_seq(input string tag, input int val, input int n, input int exp_f[4]);
    for (int k = 0; k < n; k++) begin
      cycle(1, val, 0);
      i_sel = 2'd0;
      #1;
      check($sformatf("%s.filt%0d", tag, k), int'(o_res), exp_f[k]);
      check_all(tag);
    end
  endtask

  initial begin
    int f24[4]  = '{21, 22, 23, 24};
    int f63[4]  = '{34, 44, 53, 63};
    int f0[4]   = '{47, 32, 16, 0};
    model_reset();
    do_reset();
    check_all("reset");

    cycle(1, 20, 0);
    check_all("first20");
    check("first20.const", int'(o_res), 20);

    sample_seq("s24", 24, 4, f24);
    i_sel = 2'd3; #1; check("s24.max", int'(o_res), 24);
    i_sel = 2'd2; #1; check("s24.min", int'(o_res), 20);
    sample_seq("s63", 63, 4, f63);
    sample_seq("s0", 0, 4, f0);
    i_sel = 2'd3; #1; check("wrap.max", int'(o_res), 63);
    i_sel = 2'd2; #1; check("wrap.min", int'(o_res), 0);

    cycle(0, 0, 1);
    check_all("clr_alone");
    cycle(1, 30, 0);
    check_all("clr_then30");
    i_sel = 2'd2; #1; check("clr30.min", int'(o_res), 30);
    i_sel = 2'd3; #1; check("clr30.max", int'(o_res), 30);
    cycle(1, 40, 1);
    check_all("clr_with40");
    i_sel = 2'd2; #1; check("clr40.min", int'(o_res), 40);
    i_sel = 2'd3; #1; check("clr40.max", int'(o_res), 40);

    for (int k = 1; k <= STALE; k++) begin
      cycle(0, 0, 0);
      if (k == STALE - 1) check("stale.before", int'(o_stale), 0);
      if (k == STALE)     check("stale.at", int'(o_stale), 1);
    end
    check_all("stale");
    cycle(0, 0, 0);
    check("stale.hold", int'(o_stale), 1);
    cycle(1, 33, 0);
    check("stale.drop", int'(o_stale), 0);
    check_all("stale_drop");

    cycle(1, 50, 0);
    cycle(1, 5, 0);
    do_reset();
    check_all("midreset");
    cycle(0, 0, 1);
    check_all("clr_unprimed");
    cycle(1, 10, 0);
    check_all("after_reset10");
    i_sel = 2'd0; #1; check("after_reset.filt", int'(o_res), 10);

    for (int k = 0; k < 400; k++) begin
      int v, s, c;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s = $urandom_range(0, (1 << N) - 1);
      c = ($urandom_range(0, 9) == 0) ? 1 : 0;
      if (k == 200) begin
        do_reset();
        check_all("rnd_reset");
      end
      cycle(v, s, c);
      check_all($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tempsens_result_filter.md
Name: tempsens_result_filter

Overview:
- Post-processing stage directly downstream of the temperature-sensor measurement controller.
- Consumes each raw N_VDAC-bit result as the controller latches it, and keeps a power-of-two moving average, a running minimum and a running maximum, plus a stale-data flag.
- The selected value feeds the calibration LUT / bin2dec / seg7 display path in place of the unfiltered raw register.

Parameters:
- N_VDAC, 6, result width (matches the VDAC resolution).
- LOG2_AVG, 2, log2 of the averaging window depth (window = 2**LOG2_AVG samples); legal range 1..4.
- STALE_CYCLES, 1024, clk cycles without a new result before o_stale asserts; must be ≥1.

Ports:
- clk  in  1  system clock (10 kHz on the board).
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- i_res_valid  in  1  single-cycle strobe: new raw result present on i_res_raw.
- i_res_raw  in  N_VDAC  raw DAC code from the measurement controller.
- i_sel  in  2  output select: 0=filtered, 1=raw (last sample), 2=min, 3=max.
- i_clr_minmax  in  1  single-cycle strobe: restart min/max tracking.
- o_res  out  N_VDAC  selected result (combinational mux of registered sources).
- o_res_valid  out  1  one-cycle pulse: state updated by a sample.
- o_primed  out  1  at least one sample accepted since reset.
- o_stale  out  1  no sample for STALE_CYCLES cycles.

Behaviour:
- Reset (synchronous, active-high): clears window buffer, running sum, write pointer, last-raw, min, max, stale counter; o_res_valid=0, o_primed=0, o_stale=0, o_res=0 for every i_sel. Reset asserted mid-operation discards all history; the next sample is treated as a first sample.
- Window: 2**LOG2_AVG-entry circular buffer, write pointer LOG2_AVG bits, wraps from 2**LOG2_AVG-1 to 0. Running sum width N_VDAC+LOG2_AVG; it never overflows.
- First sample after reset (o_primed=0, i_res_valid=1):
  - every buffer entry is set to the sample;
  - sum = sample << LOG2_AVG;
  - pointer = 1;
  - min = max = raw = sample;
  - o_primed is set at the same edge.
- Subsequent samples:
  - sum_next = sum − buf[wp] + sample;
  - buf[wp] = sample; wp increments;
  - raw = sample.
- Filtered output = (sum + 2**(LOG2_AVG−1)) >> LOG2_AVG (round half up), registered. The result cannot exceed all-ones, so no saturation logic.
- Latency: a sample strobed in cycle T is reflected in every source and in o_res from cycle T+1. o_res_valid is high for exactly cycle T+1. Back-to-back strobes every cycle are legal; each is accepted.
- Min/max: updated with unsigned compare on every accepted sample (min only on strictly less, max only on strictly greater).
  - i_clr_minmax alone: min and max keep their values and are flagged for reload; the next accepted sample overwrites both.
  - i_clr_minmax together with i_res_valid in the same cycle: the concurrent sample becomes both min and max.
  - i_clr_minmax before priming has no effect.
- Stale counter: saturating, range 0..STALE_CYCLES.
  - Increments every cycle without i_res_valid; cleared to 0 on i_res_valid.
  - o_stale = (counter == STALE_CYCLES), registered.
  - A valid sample deasserts o_stale at T+1.
  - Counts from reset, so o_stale asserts STALE_CYCLES cycles after reset if no sample arrives.
- i_sel is not registered; changing it changes o_res in the same cycle. Values shown before priming are 0.

Test Plan:
- Reset, then i_res_valid with raw=20 → T+1: o_res_valid=1, o_primed=1; o_res=20 for i_sel 0/1/2/3.
- LOG2_AVG=2, after 20 send 24,24,24,24 → filtered 21,22,23,24 (sums 84,88,92,96); max=24, min=20.
- Continue with 63 ×4 then 0 ×4 → filtered climbs 34,44,53,63 then 47,32,16,0; pointer wraps with no glitch; max=63, min=0; sum never exceeds 252.
- Pulse i_clr_minmax alone, then sample 30 → min=max=30. Then i_clr_minmax together with sample 40 → min=max=40.
- STALE_CYCLES=1024, no samples after priming → o_stale rises exactly 1024 cycles after the last strobe. A sample then drops o_stale at T+1.
- Assert reset during a sample stream (mid-window) → all outputs 0, o_primed=0. The next sample 10 gives filtered=min=max=10.
